// File: rtl/vga_pkg.sv
// Shared VGA timing constants and decoder state encoding.
// Generator and decoder both import this package for geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } decoder_state_t;

  localparam int PROD_H_TOTAL  = 1056;
  localparam int PROD_V_TOTAL  = 628;
  localparam int PROD_H_ACTIVE = 800;
  localparam int PROD_V_ACTIVE = 600;

  localparam int DBG_H_TOTAL  = 40;
  localparam int DBG_V_TOTAL  = 32;
  localparam int DBG_H_ACTIVE = 32;
  localparam int DBG_V_ACTIVE = 24;

  localparam int DEF_H_SLACK     = 4;
  localparam int DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Video stream in (sync/blank/pixel) and recovered timing out.
// master: generator/bench side; slave: the decoder.
interface vga_sync_decoder_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          hs_in;
  logic          vs_in;
  logic          blank_n_in;
  logic          pixel_in;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          pixel_valid;
  logic          pixel_out;
  logic          line_start;
  logic          frame_start;
  logic          locked;
  logic          timing_err;
  logic [XW-1:0] meas_h_total;
  logic [YW-1:0] meas_v_total;

  modport master (
    output hs_in, vs_in, blank_n_in, pixel_in,
    input  x_pos, y_pos, pixel_valid, pixel_out,
    input  line_start, frame_start, locked,
    input  timing_err, meas_h_total, meas_v_total
  );

  modport slave (
    input  hs_in, vs_in, blank_n_in, pixel_in,
    output x_pos, y_pos, pixel_valid, pixel_out,
    output line_start, frame_start, locked,
    output timing_err, meas_h_total, meas_v_total
  );
endinterface

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Two-flop sync register with polarity normalisation.
// Ports: clk_i, rst_i, sync_i raw in; edge_o leading-edge pulse.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic edge_o
);

  logic s1_q, s2_q;
  logic norm;

  assign norm = sync_i ^ ACTIVE_LOW;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= norm;
      s2_q <= s1_q;
    end
  end

  assign edge_o = s1_q & ~s2_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA stream and checks timing.
// Ports: CLK_40, reset (sync, high), bus (stream in, timing out).
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL         = PROD_H_TOTAL,
  parameter int V_TOTAL         = PROD_V_TOTAL,
  parameter int H_ACTIVE        = PROD_H_ACTIVE,
  parameter int V_ACTIVE        = PROD_V_ACTIVE,
  parameter int H_SLACK         = DEF_H_SLACK,
  parameter int LOCK_FRAMES     = DEF_LOCK_FRAMES,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int XW = $clog2(H_TOTAL + H_SLACK + 1),
  parameter int YW = $clog2(V_TOTAL + 1)
) (
  input logic               CLK_40,
  input logic               reset,
  vga_sync_decoder_if.slave bus
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [XW-1:0] HMAX_X = XW'(H_TOTAL + H_SLACK);
  localparam logic [XW-1:0] HTOT_X = XW'(H_TOTAL);
  localparam logic [XW-1:0] HACT_X = XW'(H_ACTIVE);
  localparam logic [YW-1:0] VTOT_Y = YW'(V_TOTAL);
  localparam logic [YW-1:0] VACT_Y = YW'(V_ACTIVE);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_FRAMES);

  logic hs_e, vs_e;

  sync_edge_detect #(
    .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
  ) u_hs (
    .clk_i  (CLK_40),
    .rst_i  (reset),
    .sync_i (bus.hs_in),
    .edge_o (hs_e)
  );

  sync_edge_detect #(
    .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
  ) u_vs (
    .clk_i  (CLK_40),
    .rst_i  (reset),
    .sync_i (bus.vs_in),
    .edge_o (vs_e)
  );

  logic           b1_q, p1_q, b2_q, p2_q;
  logic [XW-1:0]  h_cnt_q, meas_h_q, act_cnt_q, x_q;
  logic [YW-1:0]  act_lines_q, line_cnt_q, meas_v_q, y_q;
  logic           frame_bad_q, ls_q, fs_q, err_q;
  logic [GW-1:0]  good_q;
  decoder_state_t state_q;

  logic          line_close, line_bad;
  logic          frame_ok, watchdog;
  logic [XW-1:0] meas_h_d;
  logic [YW-1:0] meas_v_d, act_lines_d;

  // A line closing on the same cycle as vsync is
  // folded into the frame being evaluated.
  always_comb begin
    line_close  = hs_e && (act_cnt_q != '0);
    line_bad    = line_close && (act_cnt_q != HACT_X);
    act_lines_d = act_lines_q
                + {{(YW-1){1'b0}}, line_close};
    meas_h_d    = hs_e ? h_cnt_q + 1'b1 : meas_h_q;
    meas_v_d    = line_cnt_q
                + {{(YW-1){1'b0}}, hs_e};
    frame_ok    = (meas_h_d == HTOT_X)
               && (meas_v_d == VTOT_Y)
               && (act_lines_d == VACT_Y)
               && !(frame_bad_q || line_bad);
    watchdog    = (state_q == LOCKED)
               && (h_cnt_q == HMAX_X);
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      b1_q        <= 1'b0;
      p1_q        <= 1'b0;
      b2_q        <= 1'b0;
      p2_q        <= 1'b0;
      h_cnt_q     <= '0;
      meas_h_q    <= '0;
      act_cnt_q   <= '0;
      x_q         <= '0;
      act_lines_q <= '0;
      line_cnt_q  <= '0;
      meas_v_q    <= '0;
      y_q         <= '0;
      frame_bad_q <= 1'b0;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      good_q      <= '0;
      state_q     <= SEARCH;
    end else begin
      b1_q  <= bus.blank_n_in;
      p1_q  <= bus.pixel_in;
      b2_q  <= b1_q;
      p2_q  <= p1_q;
      ls_q  <= hs_e;
      fs_q  <= vs_e;
      err_q <= 1'b0;

      if (hs_e) begin
        h_cnt_q  <= '0;
        meas_h_q <= meas_h_d;
      end else if (h_cnt_q != HMAX_X) begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end

      if (hs_e) begin
        act_cnt_q <= {{(XW-1){1'b0}}, b1_q};
      end else if (b1_q && act_cnt_q != '1) begin
        act_cnt_q <= act_cnt_q + 1'b1;
      end
      x_q <= hs_e ? '0 : act_cnt_q;

      if (vs_e) begin
        act_lines_q <= '0;
        line_cnt_q  <= '0;
        meas_v_q    <= meas_v_d;
        frame_bad_q <= 1'b0;
        y_q         <= '0;
      end else begin
        act_lines_q <= act_lines_d;
        line_cnt_q  <= meas_v_d;
        y_q         <= act_lines_d;
        if (line_bad) frame_bad_q <= 1'b1;
      end

      unique case (state_q)
        SEARCH: begin
          if (vs_e) begin
            state_q <= MEASURE;
            good_q  <= '0;
          end
        end
        MEASURE: begin
          if (vs_e && frame_ok) begin
            good_q <= good_q + 1'b1;
            if (good_q + 1'b1 == LOCK_G)
              state_q <= LOCKED;
          end else if (vs_e) begin
            good_q <= '0;
          end
        end
        LOCKED: begin
          if (watchdog) begin
            err_q   <= 1'b1;
            state_q <= SEARCH;
            good_q  <= '0;
          end else if (vs_e && !frame_ok) begin
            err_q   <= 1'b1;
            state_q <= MEASURE;
            good_q  <= '0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign bus.locked       = (state_q == LOCKED);
  assign bus.pixel_valid  = bus.locked && b2_q;
  assign bus.pixel_out    = bus.pixel_valid && p2_q;
  assign bus.x_pos        = x_q;
  assign bus.y_pos        = y_q;
  assign bus.line_start   = ls_q;
  assign bus.frame_start  = fs_q;
  assign bus.timing_err   = err_q;
  assign bus.meas_h_total = meas_h_q;
  assign bus.meas_v_total = meas_v_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder, debug geometry.
// Frame-level lock model; pixel monitor pops expected queue.
module tb_vga_sync_decoder;
  import vga_pkg::*;

  localparam int XW = $clog2(DBG_H_TOTAL + 4 + 1);
  localparam int YW = $clog2(DBG_V_TOTAL + 1);
  localparam int SR = 0;
  localparam int MS = 1;
  localparam int LK = 2;

  typedef struct {
    int x;
    int y;
    bit p;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if #(.XW(XW), .YW(YW)) bus ();

  vga_sync_decoder #(
    .H_TOTAL         (DBG_H_TOTAL),
    .V_TOTAL         (DBG_V_TOTAL),
    .H_ACTIVE        (DBG_H_ACTIVE),
    .V_ACTIVE        (DBG_V_ACTIVE),
    .H_SLACK         (4),
    .LOCK_FRAMES     (2),
    .SYNC_ACTIVE_LOW (1),
    .XW              (XW),
    .YW              (YW)
  ) dut (
    .CLK_40 (clk),
    .reset  (rst),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  pix_t q[$];

  int m_st = SR;
  int m_good = 0;
  bit m_dirty = 0;
  int exp_err = 0;
  int fs_exp = 0;
  int ls_exp = 0;

  bit mon_en = 0;
  int err_seen = 0;
  int fs_seen = 0;
  int ls_seen = 0;
  int pv_cnt = 0;
  bit locked_seen = 0;
  bit prev_lk = 0;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    pix_t it;
    if (mon_en) begin
      if (bus.pixel_valid) begin
        pv_cnt++;
        if (q.size() == 0) begin
          chk("pix_extra", 1, 0);
        end else begin
          it = q.pop_front();
          chk("pix",
              {bus.x_pos, bus.y_pos, bus.pixel_out},
              {XW'(it.x), YW'(it.y), it.p});
        end
      end else begin
        chk("pix_zero", bus.pixel_out, 0);
      end
      if (bus.timing_err) err_seen++;
      if (bus.frame_start) fs_seen++;
      if (bus.line_start) ls_seen++;
      if (bus.locked) locked_seen = 1;
      if (bus.locked && !prev_lk)
        chk("lock_on_fs", bus.frame_start, 1);
      prev_lk = bus.locked;
    end
  end

  task automatic drive(input bit hs_a, input bit vs_a,
                       input bit bl, input bit px,
                       input bit r);
    rst = r;
    bus.hs_in = ~hs_a;
    bus.vs_in = ~vs_a;
    bus.blank_n_in = bl;
    bus.pixel_in = px;
    @(posedge clk);
    #1;
    if (r)
      chk("reset_outs",
          {bus.x_pos, bus.y_pos, bus.pixel_valid,
           bus.pixel_out, bus.line_start,
           bus.frame_start, bus.locked, bus.timing_err,
           bus.meas_h_total, bus.meas_v_total}, 0);
  endtask

  task automatic model_reset();
    m_st = SR;
    m_good = 0;
    m_dirty = 0;
  endtask

  task automatic model_vs();
    fs_exp++;
    case (m_st)
      SR: begin
        m_st = MS;
        m_good = 0;
      end
      MS: begin
        if (!m_dirty) begin
          m_good++;
          if (m_good == 2) m_st = LK;
        end else begin
          m_good = 0;
        end
      end
      default: begin
        if (m_dirty) begin
          exp_err++;
          m_st = MS;
          m_good = 0;
        end
      end
    endcase
    m_dirty = 0;
  endtask

  // Lines 0..23 active; hsync at 34..37; vsync lines 26..29.
  task automatic gen_frame(input int hlen, input int bad_line,
                           input int drop_line,
                           input int rst_line, input bit pat);
    for (int l = 0; l < 32; l++) begin
      int act;
      bit hs_a, vs_a, bl, px, r;
      if (l == 26) model_vs();
      act = (l < 24) ? ((l == bad_line) ? 31 : 32) : 0;
      for (int c = 0; c < hlen; c++) begin
        bl = c < act;
        px = pat ? (c[0] ^ l[0]) : 1'($urandom);
        hs_a = c >= 34 && c < 38 && l != drop_line;
        vs_a = l >= 26 && l < 30;
        r = (l == rst_line) && (c == 38);
        if (hs_a && c == 34) ls_exp++;
        if (r) model_reset();
        if (bl && m_st == LK)
          q.push_back('{x: c, y: l, p: px});
        drive(hs_a, vs_a, bl, px, r);
      end
      if (hlen != 40 || (l < 24 && act != 32)
          || l == drop_line)
        m_dirty = 1;
      if (l == drop_line && m_st == LK) begin
        exp_err++;
        m_st = SR;
      end
    end
  endtask

  task automatic end_chk(input string tag);
    chk({tag, "_locked"}, bus.locked, m_st == LK);
    chk({tag, "_err"}, err_seen, exp_err);
    chk({tag, "_fs"}, fs_seen, fs_exp);
    chk({tag, "_ls"}, ls_seen, ls_exp);
    chk({tag, "_q"}, q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
    model_reset();
    mon_en = 1;

    for (int f = 0; f < 4; f++) gen_frame(40, -1, -1, -1, 0);
    end_chk("clean");
    chk("clean_lock", bus.locked, 1);
    chk("clean_mh", bus.meas_h_total, 40);
    chk("clean_mv", bus.meas_v_total, 32);
    chk("clean_noerr", err_seen, 0);

    pv_cnt = 0;
    for (int f = 0; f < 2; f++) gen_frame(40, -1, -1, -1, 1);
    chk("pat_count", pv_cnt, 2 * 32 * 24);
    end_chk("pat");

    gen_frame(40, -1, $urandom_range(0, 23), -1, 0);
    chk("wd_err", err_seen, 1);
    chk("wd_unlock", bus.locked, 0);
    for (int f = 0; f < 2; f++) gen_frame(40, -1, -1, -1, 0);
    end_chk("wd");

    gen_frame(40, $urandom_range(0, 23), -1, -1, 0);
    chk("act_err", err_seen, 2);
    chk("act_unlock", bus.locked, 0);
    for (int f = 0; f < 2; f++) gen_frame(40, -1, -1, -1, 0);
    end_chk("act");

    gen_frame(40, -1, -1, $urandom_range(0, 23), 0);
    chk("rst_unlock", bus.locked, 0);
    for (int f = 0; f < 2; f++) gen_frame(40, -1, -1, -1, 0);
    end_chk("rst");
    chk("rst_relock", bus.locked, 1);

    gen_frame(41, -1, -1, 0, 0);
    locked_seen = 0;
    for (int f = 0; f < 3; f++) gen_frame(41, -1, -1, -1, 0);
    end_chk("long");
    chk("long_mh", bus.meas_h_total, 41);
    chk("long_mv", bus.meas_v_total, 32);
    chk("long_nolock", locked_seen, 0);
    chk("long_state", dut.state_q, MEASURE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
